bitrev_descramble: RTL
======================

// Module: bitrev_descramble
// PURPOSE
//   Inverse companion of the natural->bit-reversed reorder stage. Accepts a stream in
//   bit-reversed index order (e.g. radix-2 DIT FFT output) and emits it in natural order.
//   Sits between the FFT core and downstream consumers in the user domain. Uses a
//   flop-based ping-pong store of two N-deep banks with full back-pressure on both sides.
// PARAMETERS
//   K   10  log2(frame length N); N = 2**K. K >= 1.
//   DW  32  data width in bits.
// PORTS
//   clk_i        in   1      sole clock; all logic on rising edge
//   rst_i        in   1      synchronous reset, active-high
//   valid_i      in   1      input word valid
//   data_i       in   DW     input word; j-th word of a frame belongs at natural index bitrev(j)
//   ready_o      out  1      block can accept data_i this cycle
//   valid_o      out  1      output word valid
//   data_o       out  DW     output word, natural order
//   last_o       out  1      high with valid_o on natural index N-1
//   ready_i      in   1      consumer accepts data_o
//   frames_o     out  2      number of complete frames held (0..2)
// BEHAVIOUR
//   - Handshakes: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i. valid_o and data_o
//     are held stable until out_fire. ready_o does not depend on valid_i.
//   - State: wr_cnt[K-1:0], wr_bank, rd_cnt[K-1:0], rd_bank, full_q[1:0]; mem[2*N] x DW.
//   - Reset (rst_i=1 at edge): wr_cnt=rd_cnt=0, wr_bank=rd_bank=0, full_q=00. Memory is not
//     cleared. Outputs after reset: ready_o=1, valid_o=0, last_o=0, frames_o=0, data_o=don't-care.
//   - Write: ready_o = ~full_q[wr_bank]. On in_fire: mem[{wr_bank, bitrev(wr_cnt)}] <= data_i;
//     wr_cnt increments mod N. When wr_cnt==N-1, set full_q[wr_bank] and toggle wr_bank.
//   - Read (combinational data path): valid_o = full_q[rd_bank]; data_o = mem[{rd_bank, rd_cnt}];
//     last_o = valid_o & (rd_cnt==N-1). On out_fire rd_cnt increments mod N; when rd_cnt==N-1,
//     clear full_q[rd_bank] and toggle rd_bank.
//   - Latency: first valid_o in the cycle after the N-th in_fire of a frame. Throughput 1 word/cycle
//     sustained when both sides are always ready.
//   - Simultaneous set (write side) and clear (read side) in one cycle always target different
//     banks; both take effect. frames_o = full_q[0] + full_q[1], registered via full_q.
//   - Both banks full: ready_o=0 until the read bank drains its last word. ready_o rises in the
//     cycle after that out_fire, never in the same cycle.
//   - Mid-frame reset discards partial and complete frames; no output word after reset until a
//     fresh full frame is written.
//   - bitrev(x)[i] = x[K-1-i]. All counters wrap silently; no overflow signalling.
// CONFIGURATION
//   BITREV_DESCRAMBLE_LAST_CHECK_EN defined:
//     - Adds input last_i (1, marks the final input word of a frame).
//     - Adds output frame_err_o (1, sticky).
//     - frame_err_o sets on any in_fire where last_i != (wr_cnt==N-1).
//     - frame_err_o clears only on rst_i. Data flow is unaffected.
//   Not defined: neither port exists; there is no framing check.
// TESTING (K=3, N=8, DW=32 unless noted)
//   1. Write data = bitrev(j) for j=0..7 (0,4,2,6,1,5,3,7), ready_i=1 -> data_o 0..7 in order;
//      valid_o first high the cycle after the 8th write; last_o only with 7; frames_o back to 0.
//   2. ready_i=0, 24 words offered back-to-back -> ready_o drops after the 16th in_fire;
//      frames_o=2. Raise ready_i -> after 8 out_fires ready_o=1 the next cycle; words 17..24 accepted.
//   3. Continuous streaming of 4 frames, valid_i=ready_i=1 -> 32 outputs, correct per-frame
//      order, no bubbles after the first frame, bank alternation verified.
//   4. ready_i toggling randomly 50% during frame 1 -> data_o/valid_o stable while stalled;
//      output sequence unchanged vs scenario 1.
//   5. Assert rst_i after 5 writes and 3 reads of frame 2 -> next cycle valid_o=0, frames_o=0,
//      ready_o=1; a new frame reads back correctly.
//   6. With BITREV_DESCRAMBLE_LAST_CHECK_EN, last_i pulsed on the 6th word -> frame_err_o=1
//      the next cycle and held; output data still in the scenario-1 order.

Source files
------------

// File: rtl/bitrev_descramble.sv
// Bit-reversed to natural order reorder stage: two N-deep flop banks used as a ping-pong store.
// Optional framing check enabled by defining BITREV_DESCRAMBLE_LAST_CHECK_EN (adds last_i, frame_err_o).
module bitrev_descramble #(
  parameter int K  = 10,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
`ifdef BITREV_DESCRAMBLE_LAST_CHECK_EN
  input  logic          last_i,
  output logic          frame_err_o,
`endif
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  input  logic          ready_i,
  output logic [1:0]    frames_o
);

  localparam int N  = 1 << K;
  localparam int AW = K + 1;

  function automatic logic [K-1:0] bitrev(input logic [K-1:0] x);
    logic [K-1:0] r;
    for (int i = 0; i < K; i++) r[i] = x[K-1-i];
    return r;
  endfunction

  logic [K-1:0]  wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic [K-1:0]  rd_cnt_q, rd_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic [DW-1:0] mem_q [2*N];

  logic          in_fire, out_fire;
  logic          wr_last, rd_last;
  logic [AW-1:0] wr_addr, rd_addr;

  assign ready_o  = ~full_q[wr_bank_q];
  assign valid_o  = full_q[rd_bank_q];
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;
  assign wr_last  = (wr_cnt_q == {K{1'b1}});
  assign rd_last  = (rd_cnt_q == {K{1'b1}});
  assign wr_addr  = {wr_bank_q, bitrev(wr_cnt_q)};
  assign rd_addr  = {rd_bank_q, rd_cnt_q};

  assign data_o   = mem_q[rd_addr];
  assign last_o   = valid_o & rd_last;
  assign frames_o = {1'b0, full_q[0]} + {1'b0, full_q[1]};

  // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    if (in_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    // A write-side set and a read-side clear in the same cycle always hit different banks.
    if (out_fire) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; full_q alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (in_fire) mem_q[wr_addr] <= data_i;
  end

`ifdef BITREV_DESCRAMBLE_LAST_CHECK_EN
  logic frame_err_q, frame_err_d;

  assign frame_err_d = frame_err_q | (in_fire & (last_i != wr_last));
  assign frame_err_o = frame_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) frame_err_q <= 1'b0;
    else       frame_err_q <= frame_err_d;
  end
`endif

endmodule
